// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, FSM state type and frame length helper.
package uart_pkg;

   // parity_mode encodings; 2'b11 behaves like PAR_NONE
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Wide enough for the longest frame: 1 + 9 + 1 + 2 = 13 bits
   localparam int BIT_CNT_W = $clog2(12);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } tx_state_t;

   // True when the mode code inserts a parity bit
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Frame length in bit times: start + data + optional parity + stop bits
   function automatic logic [BIT_CNT_W-1:0] frame_len(input int data_bits,
                                                      input logic par_en,
                                                      input logic two_stop);
      return BIT_CNT_W'(1 + data_bits + int'(par_en) + (two_stop ? 2 : 1));
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop handshakes, full/empty flags and fill level.
// Pushes into a full FIFO and pops from an empty one are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array write port
   // NOTE: the data array has no reset; entries are only read after being written, and resetting it would force flops instead of RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. Frames are start, data LSB first,
// optional parity, one or two stop bits; one bit per uart_clk tick, and a new
// frame starts on the very tick that ends the previous one while data waits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         uart_clk,
   input  logic                         s_valid,
   input  logic [DATA_BITS-1:0]         s_data,
   output logic                         s_ready,
   input  logic [1:0]                   parity_mode,
   input  logic                         two_stop,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         tx_busy,
   output logic                         txd
);

   localparam int SH_W = DATA_BITS + 3;

   tx_state_t              state;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [BIT_CNT_W-1:0]   frame_last;
   logic [SH_W-1:0]        shreg;

   logic [DATA_BITS-1:0]   head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   frame_done;
   logic                   start_frame;
   logic                   par_en;
   logic                   par_bit;
   logic [SH_W-1:0]        next_frame;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s_valid),
      .push_data (s_data),
      .pop       (start_frame),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // Last bit of the current frame is on the line; the next tick ends it
   assign frame_done  = (state == ST_SHIFT) && (bit_cnt == frame_last);
   // Emptiness comes from the registered count, so a word pushed this cycle waits for a later tick
   assign start_frame = uart_clk && !fifo_empty && ((state == ST_IDLE) || frame_done);

   assign s_ready = !fifo_full;
   assign tx_busy = (state == ST_SHIFT) || !fifo_empty;

   // Bits following the start bit, sampled from the head word and current config
   // NOTE: every always_comb output is assigned on every path so no latch is inferred.
   always_comb begin
      par_en     = par_enabled(parity_mode);
      par_bit    = (parity_mode == PAR_ODD) ? ~^head : ^head;
      next_frame = {2'b11, (par_en ? par_bit : 1'b1), head};
   end

   // Transmit FSM: loads a frame on start, then shifts one bit per tick; txd is registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         frame_last <= '0;
         shreg      <= '1;
         txd        <= 1'b1;
      end else if (uart_clk) begin
         if (start_frame) begin
            state      <= ST_SHIFT;
            txd        <= 1'b0;
            shreg      <= next_frame;
            bit_cnt    <= '0;
            frame_last <= frame_len(DATA_BITS, par_en, two_stop) - BIT_CNT_W'(1);
         end else if (frame_done) begin
            state <= ST_IDLE;
            txd   <= 1'b1;
         end else if (state == ST_SHIFT) begin
            txd     <= shreg[0];
            shreg   <= {1'b1, shreg[SH_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: an 8-bit and a 5-bit transmitter against a frame-level
// reference model (word queue plus per-frame bit list), with directed scenarios
// followed by randomized pushes, ticks and configuration changes.
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic uart_clk;

   logic       a_valid;
   logic [7:0] a_data;
   logic       a_ready;
   logic [1:0] a_pm;
   logic       a_ts;
   logic [2:0] a_level;
   logic       a_busy;
   logic       a_txd;

   logic       b_valid;
   logic [4:0] b_data;
   logic       b_ready;
   logic [1:0] b_pm;
   logic       b_ts;
   logic [2:0] b_level;
   logic       b_busy;
   logic       b_txd;

   // reference model state, index 0 = 8-bit instance, 1 = 5-bit instance
   logic [8:0]  m_q      [2][DEPTH];
   int          m_cnt    [2];
   bit          m_active [2];
   logic [15:0] m_frame  [2];
   int          m_len    [2];
   int          m_idx    [2];
   logic        m_txd    [2];

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] log_a;
   logic [63:0] log_b;
   int          n_log_a;
   int          n_log_b;

   bit tick_en;
   bit tick_rand;
   int gap;
   logic t_sample;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut_a (
      .clk         (clk),
      .rst         (rst),
      .uart_clk    (uart_clk),
      .s_valid     (a_valid),
      .s_data      (a_data),
      .s_ready     (a_ready),
      .parity_mode (a_pm),
      .two_stop    (a_ts),
      .fifo_level  (a_level),
      .tx_busy     (a_busy),
      .txd         (a_txd)
   );

   uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .uart_clk    (uart_clk),
      .s_valid     (b_valid),
      .s_data      (b_data),
      .s_ready     (b_ready),
      .parity_mode (b_pm),
      .two_stop    (b_ts),
      .fifo_level  (b_level),
      .tx_busy     (b_busy),
      .txd         (b_txd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame as a list of line levels: index 0 is the start bit
   function automatic logic [15:0] build_frame(input int db, input logic [8:0] d,
                                               input logic [1:0] pm, input logic ts,
                                               output int len);
      logic [15:0] f;
      int n;
      int ones;
      f    = '1;
      ones = 0;
      f[0] = 1'b0;
      n    = 1;
      for (int i = 0; i < db; i++) begin
         f[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (pm == 2'b01) begin
         f[n] = ((ones % 2) == 1);
         n++;
      end else if (pm == 2'b10) begin
         f[n] = ((ones % 2) == 0);
         n++;
      end
      n   += ts ? 2 : 1;
      len  = n;
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k]    = 0;
         m_active[k] = 1'b0;
         m_txd[k]    = 1'b1;
         m_idx[k]    = 0;
         m_len[k]    = 0;
         m_frame[k]  = '1;
      end
   endtask

   // One clk edge of the model, using the input values present before the edge
   task automatic model_step(input int k, input int db, input logic sv, input logic [8:0] sd,
                             input logic [1:0] pm, input logic ts, input logic tick);
      bit push;
      int len;
      push = sv && (m_cnt[k] < DEPTH);
      if (tick) begin
         if (m_active[k] && (m_idx[k] < m_len[k] - 1)) begin
            m_idx[k]++;
            m_txd[k] = m_frame[k][m_idx[k]];
         end else if (m_cnt[k] > 0) begin
            m_frame[k] = build_frame(db, m_q[k][0], pm, ts, len);
            m_len[k]   = len;
            for (int i = 0; i < DEPTH - 1; i++) m_q[k][i] = m_q[k][i+1];
            m_cnt[k]--;
            m_idx[k]    = 0;
            m_active[k] = 1'b1;
            m_txd[k]    = m_frame[k][0];
         end else begin
            m_active[k] = 1'b0;
            m_txd[k]    = 1'b1;
         end
      end
      if (push) begin
         m_q[k][m_cnt[k]] = sd;
         m_cnt[k]++;
      end
   endtask

   // Model update on each rising edge; also logs the DUT line level on frame ticks
   initial begin
      forever begin
         @(posedge clk);
         t_sample = uart_clk;
         if (rst) begin
            model_reset();
         end else begin
            model_step(0, 8, a_valid, {1'b0, a_data}, a_pm, a_ts, t_sample);
            model_step(1, 5, b_valid, {4'b0, b_data}, b_pm, b_ts, t_sample);
            if (t_sample) begin
               #1;
               if (m_active[0] && n_log_a < 64) begin
                  log_a[n_log_a] = a_txd;
                  n_log_a++;
               end
               if (m_active[1] && n_log_b < 64) begin
                  log_b[n_log_b] = b_txd;
                  n_log_b++;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      forever begin
         @(negedge clk);
         check("a_txd",   32'(a_txd),   32'(m_txd[0]));
         check("a_level", 32'(a_level), 32'(m_cnt[0]));
         check("a_busy",  32'(a_busy),  32'(m_active[0] || m_cnt[0] > 0));
         check("a_ready", 32'(a_ready), 32'(m_cnt[0] < DEPTH));
         check("b_txd",   32'(b_txd),   32'(m_txd[1]));
         check("b_level", 32'(b_level), 32'(m_cnt[1]));
         check("b_busy",  32'(b_busy),  32'(m_active[1] || m_cnt[1] > 0));
         check("b_ready", 32'(b_ready), 32'(m_cnt[1] < DEPTH));
      end
   end

   // Baud tick source: fixed 1-in-16 or random spacing, one clk wide
   initial begin
      uart_clk = 1'b0;
      gap      = 0;
      forever begin
         @(negedge clk);
         if (tick_en && gap == 0) begin
            uart_clk = 1'b1;
            gap      = tick_rand ? int'($urandom_range(0, 5)) : 15;
         end else begin
            uart_clk = 1'b0;
            if (gap > 0) gap--;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic push_a(input logic [7:0] d);
      a_data  = d;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic push_b(input logic [4:0] d);
      b_data  = d;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int c;
      c = 0;
      while ((m_active[0] || m_cnt[0] != 0 || m_active[1] || m_cnt[1] != 0) && c < bound) begin
         @(negedge clk);
         c++;
      end
      check("drain_timeout", 32'(c >= bound), 32'd0);
   endtask

   task automatic wait_bits(input int n, input int bound);
      int c;
      c = 0;
      while (n_log_a < n && c < bound) begin
         @(negedge clk);
         c++;
      end
      check("bits_timeout", 32'(c >= bound), 32'd0);
   endtask

   initial begin
      logic [7:0] w1;
      logic [7:0] w2;
      rst       = 1'b1;
      a_valid   = 1'b0;
      a_data    = '0;
      a_pm      = 2'b01;
      a_ts      = 1'b0;
      b_valid   = 1'b0;
      b_data    = '0;
      b_pm      = 2'b00;
      b_ts      = 1'b0;
      tick_en   = 1'b1;
      tick_rand = 1'b0;
      n_log_a   = 0;
      n_log_b   = 0;
      log_a     = '0;
      log_b     = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_txd",   32'(a_txd),   32'd1);
      check("rst_busy",  32'(a_busy),  32'd0);
      check("rst_level", 32'(a_level), 32'd0);
      check("rst_ready", 32'(a_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // 8E1 frame of 0xA5
      n_log_a = 0;
      push_a(8'hA5);
      wait_drain(600);
      check("t1_len",  32'(n_log_a),     32'd11);
      check("t1_bits", 32'(log_a[10:0]), 32'(11'b10101001010));
      check("t1_busy", 32'(a_busy),      32'd0);

      // 8O2 frame of 0xA5
      a_pm    = 2'b10;
      a_ts    = 1'b1;
      n_log_a = 0;
      push_a(8'hA5);
      wait_drain(600);
      check("t2_len",  32'(n_log_a),     32'd12);
      check("t2_bits", 32'(log_a[11:0]), 32'(12'b111101001010));

      // fill with ticks stopped, overflow push, then back-to-back drain
      a_pm    = 2'b01;
      a_ts    = 1'b0;
      tick_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) push_a(8'($urandom));
      check("t3_level", 32'(a_level), 32'd4);
      check("t3_ready", 32'(a_ready), 32'd0);
      push_a(8'h3C);
      check("t3_level_ovf", 32'(a_level), 32'd4);
      n_log_a = 0;
      tick_en = 1'b1;
      wait_drain(2000);
      check("t3_total_bits", 32'(n_log_a), 32'd44);

      // 5N1 frame of 0x13
      n_log_b = 0;
      push_b(5'h13);
      wait_drain(600);
      check("t4_len",  32'(n_log_b),    32'd7);
      check("t4_bits", 32'(log_b[6:0]), 32'(7'b1100110));

      // asynchronous reset in the middle of the data bits
      n_log_a = 0;
      push_a(8'h00);
      push_a(8'h00);
      wait_bits(4, 400);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("t5_txd",   32'(a_txd),   32'd1);
      check("t5_level", 32'(a_level), 32'd0);
      check("t5_busy",  32'(a_busy),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_log_a = 0;
      push_a(8'h5A);
      wait_drain(600);
      check("t5_len", 32'(n_log_a), 32'd11);

      // parity mode flipped while the first of two frames is on the line
      w1      = 8'($urandom);
      w2      = 8'($urandom);
      a_pm    = 2'b01;
      n_log_a = 0;
      push_a(w1);
      push_a(w2);
      wait_bits(3, 400);
      a_pm = 2'b10;
      wait_drain(1000);
      check("t6_len",  32'(n_log_a),  32'd22);
      check("t6_par1", 32'(log_a[9]),  32'(^w1));
      check("t6_par2", 32'(log_a[20]), 32'(~^w2));

      // randomized traffic, tick spacing and configuration
      tick_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         a_valid = ($urandom_range(0, 2) == 0);
         a_data  = 8'($urandom);
         b_valid = ($urandom_range(0, 2) == 0);
         b_data  = 5'($urandom);
         if ($urandom_range(0, 150) == 0) begin
            a_pm = 2'($urandom);
            a_ts = 1'($urandom);
            b_pm = 2'($urandom);
            b_ts = 1'($urandom);
         end
         if (i == 1500) begin
            #2;
            rst = 1'b1;
            model_reset();
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      wait_drain(5000);
      check("end_busy_a", 32'(a_busy), 32'd0);
      check("end_busy_b", 32'(b_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
